// File: rtl/count_sched_pkg.sv
// Shared types and constants for the count job scheduler and its arbiter.
// The pointer helper keeps the round-robin wrap rule in one place.
package count_sched_pkg;

   localparam int NUM_W      = 4;
   localparam int CNT_W      = 8;
   localparam int N_REQ_DEF  = 4;
   localparam int STEP_W_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } sched_state_e;

   // Priority moves to the requester just after the one granted.
   function automatic int rr_next(input int idx, input int n);
      if (idx >= n - 1) begin
         return 0;
      end else begin
         return idx + 1;
      end
   endfunction

endpackage

// File: rtl/count_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after the priority pointer and returns it one-hot plus as an index.
module rr_arbiter
   import count_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   int         sum;
   logic [IDX_W-1:0] cand;
   logic             found;

   // Scan requesters in priority order starting from the pointer.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found   = 1'b0;
      sum     = 0;
      cand    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = int'(ptr_i) + k;
         if (sum >= N_REQ) begin
            sum = sum - N_REQ;
         end else begin
            sum = sum;
         end
         cand = IDX_W'(sum);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end else begin
            found = found;
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/count_job_scheduler.sv
// Time-shares one accumulating counter datapath between N_REQ requesters:
// round-robin grant, run for the requested steps, capture and return result.
module count_job_scheduler
   import count_sched_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int STEP_W = STEP_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_i,
   input  logic [NUM_W*N_REQ-1:0]  req_number_i,
   input  logic [STEP_W*N_REQ-1:0] req_steps_i,
   output logic [N_REQ-1:0]        grant_o,
   output logic [N_REQ-1:0]        done_o,
   output logic [CNT_W-1:0]        result_count_o,
   output logic                    result_ovf_o,
   output logic                    busy_o,
   output logic                    dp_start_o,
   output logic [NUM_W-1:0]        dp_number_o,
   input  logic [CNT_W-1:0]        dp_count_i,
   input  logic                    dp_overflow_i
);

   localparam int IDX_W = $clog2(N_REQ);

   sched_state_e      state_q;
   logic [IDX_W-1:0]  ptr_q;
   logic [IDX_W-1:0]  ptr_d;
   logic [N_REQ-1:0]  owner_q;
   logic [N_REQ-1:0]  grant_q;
   logic [N_REQ-1:0]  done_q;
   logic [NUM_W-1:0]  num_q;
   logic [STEP_W-1:0] cnt_q;
   logic [CNT_W-1:0]  res_cnt_q;
   logic              res_ovf_q;
   logic              busy_q;
   logic              dp_start_q;
   logic [NUM_W-1:0]  dp_number_q;

   logic [N_REQ-1:0]  win_oh_s;
   logic [IDX_W-1:0]  win_idx_s;
   logic              win_valid_s;
   logic [NUM_W-1:0]  num_sel_s;
   logic [STEP_W-1:0] steps_sel_s;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .gnt_o   (win_oh_s),
      .idx_o   (win_idx_s),
      .valid_o (win_valid_s)
   );

   // One-hot mux of the winner's number and step count.
   always_comb begin
      num_sel_s   = '0;
      steps_sel_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_oh_s[i]) begin
            num_sel_s   = num_sel_s   | req_number_i[i*NUM_W +: NUM_W];
            steps_sel_s = steps_sel_s | req_steps_i[i*STEP_W +: STEP_W];
         end else begin
            num_sel_s   = num_sel_s;
            steps_sel_s = steps_sel_s;
         end
      end
      ptr_d = IDX_W'(rr_next(int'(win_idx_s), N_REQ));
   end

   // Scheduler FSM. The grant cycle is the second IDLE cycle: req is not
   // resampled while grant_q is high, so a held request is not re-served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         grant_q     <= '0;
         done_q      <= '0;
         num_q       <= '0;
         cnt_q       <= '0;
         res_cnt_q   <= '0;
         res_ovf_q   <= 1'b0;
         busy_q      <= 1'b0;
         dp_start_q  <= 1'b0;
         dp_number_q <= '0;
      end else begin
         grant_q <= '0;
         done_q  <= '0;
         case (state_q)
            ST_IDLE: begin
               if (grant_q != '0) begin
                  busy_q     <= 1'b1;
                  dp_start_q <= 1'b1;
                  if (cnt_q != '0) begin
                     state_q     <= ST_RUN;
                     dp_number_q <= num_q;
                  end else begin
                     state_q     <= ST_CAPTURE;
                     dp_number_q <= '0;
                  end
               end else if (win_valid_s) begin
                  grant_q <= win_oh_s;
                  owner_q <= win_oh_s;
                  num_q   <= num_sel_s;
                  cnt_q   <= steps_sel_s;
                  ptr_q   <= ptr_d;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               cnt_q <= cnt_q - STEP_W'(1);
               if (cnt_q == STEP_W'(1)) begin
                  state_q     <= ST_CAPTURE;
                  dp_number_q <= '0;
               end else begin
                  state_q <= ST_RUN;
               end
            end
            ST_CAPTURE: begin
               res_cnt_q  <= dp_count_i;
               res_ovf_q  <= dp_overflow_i;
               done_q     <= owner_q;
               dp_start_q <= 1'b0;
               state_q    <= ST_DONE;
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q     <= ST_IDLE;
               busy_q      <= 1'b0;
               dp_start_q  <= 1'b0;
               dp_number_q <= '0;
            end
         endcase
      end
   end

   assign grant_o        = grant_q;
   assign done_o         = done_q;
   assign result_count_o = res_cnt_q;
   assign result_ovf_o   = res_ovf_q;
   assign busy_o         = busy_q;
   assign dp_start_o     = dp_start_q;
   assign dp_number_o    = dp_number_q;

endmodule

// File: tb/tb_count_job_scheduler.sv
// Scoreboard bench for count_job_scheduler with a behavioural counter
// datapath; directed jobs push expected grants and results into queues.
module tb_count_job_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = 4'b0000;
   logic [15:0] req_number = 16'h0000;
   logic [19:0] req_steps = 20'h00000;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic [7:0]  result_count;
   logic        result_ovf;
   logic        busy;
   logic        dp_start;
   logic [3:0]  dp_number;
   logic [7:0]  dp_count = 8'd0;
   logic        dp_overflow = 1'b0;
   logic [8:0]  dp_sum;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int start_cnt = 0;

   typedef struct { int idx; int cyc; } gexp_t;
   typedef struct { int idx; int cyc; int cnt; int ovf; int starts; } dexp_t;
   gexp_t exp_g[$];
   dexp_t exp_d[$];

   count_job_scheduler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_i          (req),
      .req_number_i   (req_number),
      .req_steps_i    (req_steps),
      .grant_o        (grant),
      .done_o         (done),
      .result_count_o (result_count),
      .result_ovf_o   (result_ovf),
      .busy_o         (busy),
      .dp_start_o     (dp_start),
      .dp_number_o    (dp_number),
      .dp_count_i     (dp_count),
      .dp_overflow_i  (dp_overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference accumulating datapath: clear when start is low, sticky carry.
   assign dp_sum = {1'b0, dp_count} + {5'b00000, dp_number};
   always @(posedge clk) begin
      if (!dp_start) begin
         dp_count    <= 8'd0;
         dp_overflow <= 1'b0;
      end else begin
         dp_count    <= dp_sum[7:0];
         dp_overflow <= dp_overflow | dp_sum[8];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Monitor: pop and compare whenever the DUT presents a grant or done.
   always @(negedge clk) begin
      gexp_t g;
      dexp_t d;
      if (rst_n) begin
         if (dp_start) start_cnt++;
         if (grant != 4'b0000) begin
            check("grant_onehot", $countones(grant), 1);
            if (exp_g.size() == 0) begin
               check("grant_unexpected", grant, 0);
            end else begin
               g = exp_g.pop_front();
               check("grant_vec", grant, 32'(1) << g.idx);
               check("grant_cycle", cyc, g.cyc);
            end
            start_cnt = 0;
         end
         if (done != 4'b0000) begin
            if (exp_d.size() == 0) begin
               check("done_unexpected", done, 0);
            end else begin
               d = exp_d.pop_front();
               check("done_vec", done, 32'(1) << d.idx);
               check("done_cycle", cyc, d.cyc);
               check("result_count", result_count, d.cnt);
               check("result_ovf", result_ovf, d.ovf);
               check("dp_start_cycles", start_cnt, d.starts);
            end
         end
      end
   end

   task automatic set_slot(input int idx, input logic [3:0] num, input logic [4:0] steps);
      req_number[idx*4 +: 4] = num;
      req_steps[idx*5 +: 5]  = steps;
   endtask

   task automatic exp_job(input int idx, input int gcyc, input int steps, input int cnt, input int ovf);
      exp_g.push_back('{idx: idx, cyc: gcyc});
      exp_d.push_back('{idx: idx, cyc: gcyc + steps + 2, cnt: cnt, ovf: ovf, starts: steps + 1});
   endtask

   // Drop each requester after its grant; bits in rearm are raised once more.
   task automatic wait_grants(input int n, input logic [3:0] rearm);
      int got = 0;
      for (int t = 0; t < 200 && got < n; t++) begin
         @(negedge clk);
         if (grant != 4'b0000) begin
            req = req & ~grant;
            if ((rearm & grant) != 4'b0000) begin
               req   = req | (rearm & grant);
               rearm = 4'b0000;
            end
            got++;
         end
      end
      if (got < n) fail_now("wait_grants");
   endtask

   // Returns at the negedge of the IDLE cycle following the last done.
   task automatic wait_idle();
      int t;
      for (t = 0; t < 200; t++) begin
         @(negedge clk);
         #1;
         if (exp_d.size() == 0 && exp_g.size() == 0) break;
      end
      if (t >= 200) fail_now("wait_idle");
      @(negedge clk);
   endtask

   initial begin
      int x;
      repeat (3) @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_dp_start", dp_start, 0);
      check("rst_dp_number", dp_number, 0);
      check("rst_result_count", result_count, 0);
      check("rst_result_ovf", result_ovf, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Contention: all four held, grants 0,1,2,3 five cycles apart.
      for (int i = 0; i < 4; i++) set_slot(i, 4'(i + 1), 5'd1);
      x = cyc;
      req = 4'b1111;
      for (int i = 0; i < 4; i++) exp_job(i, x + 1 + 5 * i, 1, i + 1, 0);
      wait_grants(4, 4'b0000);
      wait_idle();

      // Fairness after wrap: 0 first, then 3 wins over a re-raised 0.
      set_slot(0, 4'd6, 5'd2);
      set_slot(3, 4'd7, 5'd2);
      x = cyc;
      req = 4'b1001;
      exp_job(0, x + 1, 2, 12, 0);
      exp_job(3, x + 7, 2, 14, 0);
      exp_job(0, x + 13, 2, 12, 0);
      wait_grants(3, 4'b0001);
      wait_idle();

      // Single job: 4 x 3.
      set_slot(0, 4'd4, 5'd3);
      x = cyc;
      req = 4'b0001;
      exp_job(0, x + 1, 3, 12, 0);
      wait_grants(1, 4'b0000);
      wait_idle();

      // Zero steps: result is the cleared datapath.
      set_slot(1, 4'd9, 5'd0);
      x = cyc;
      req = 4'b0010;
      exp_job(1, x + 1, 0, 0, 0);
      wait_grants(1, 4'b0000);
      wait_idle();

      // Overflow: 15 x 20 = 300.
      set_slot(2, 4'd15, 5'd20);
      x = cyc;
      req = 4'b0100;
      exp_job(2, x + 1, 20, 44, 1);
      wait_grants(1, 4'b0000);
      wait_idle();

      // Reset in the middle of a 10-step run; no done may follow.
      set_slot(0, 4'd3, 5'd10);
      x = cyc;
      req = 4'b0001;
      exp_g.push_back('{idx: 0, cyc: x + 1});
      wait_grants(1, 4'b0000);
      repeat (3) @(negedge clk);
      check("run_busy", busy, 1);
      check("run_dp_start", dp_start, 1);
      check("run_dp_number", dp_number, 3);
      #2 rst_n = 1'b0;
      #1;
      check("abort_grant", grant, 0);
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
      check("abort_dp_start", dp_start, 0);
      check("abort_dp_number", dp_number, 0);
      check("abort_result_count", result_count, 0);
      check("abort_result_ovf", result_ovf, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Pointer back at 0: req 0 served before req 1.
      set_slot(0, 4'd5, 5'd2);
      x = cyc;
      req = 4'b0011;
      exp_job(0, x + 1, 2, 10, 0);
      exp_job(1, x + 7, 0, 0, 0);
      wait_grants(2, 4'b0000);
      wait_idle();

      check("left_grants", exp_g.size(), 0);
      check("left_dones", exp_d.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
